// File: rtl/bench_pkg.sv
// Shared types and helpers for the benchmark sequencer and its debouncer.
package bench_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StWait,
    StCmp,
    StDone
  } seq_state_e;

  // Result word stored for a condition that hit the timeout.
  function automatic logic [63:0] all_ones(input int unsigned width);
    return (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
  endfunction

  // Low bit of result slot idx inside the packed t_all vector.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, stability counter and rising-edge pulse for a raw push-button.
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 1_250_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  localparam int unsigned DbW = $clog2(DB_CYCLES + 1);

  logic           sync1_q, sync2_q, level_q, rise_q;
  logic [DbW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      rise_q  <= 1'b0;
      // Count consecutive samples that disagree with the current level.
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DbW'(DB_CYCLES - 1)) begin
        level_q <= sync2_q;
        rise_q  <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/bench_sequencer.sv
// Runs N_COND engine conditions back-to-back, times each one and picks the fastest.
module bench_sequencer
  import bench_pkg::*;
#(
  parameter int unsigned N_COND    = 4,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned TIMEOUT   = 2**24,
  parameter int unsigned DB_CYCLES = 1_250_000,
  parameter int unsigned LED_W     = 4,
  localparam int unsigned IDX_W    = $clog2(N_COND)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_btn,
  input  logic                    disp_mode,
  output logic [IDX_W-1:0]        cond_idx,
  output logic                    cond_start,
  input  logic                    cond_done,
  output logic [N_COND*CNT_W-1:0] t_all,
  output logic [N_COND-1:0]       timed_out,
  output logic [IDX_W-1:0]        winner,
  output logic                    winner_vld,
  output logic                    busy,
  output logic [LED_W-1:0]        led
);

  localparam logic [CNT_W-1:0] ToVal  = CNT_W'(all_ones(CNT_W));
  localparam logic [CNT_W-1:0] ToCnt  = CNT_W'(TIMEOUT);
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N_COND - 1);

  seq_state_e        state_q;
  logic              start_req;
  logic [CNT_W-1:0]  count_q, count_inc;
  logic [CNT_W-1:0]  res_q [N_COND];
  logic [N_COND-1:0] progress_q;
  logic [IDX_W-1:0]  cmp_idx_q, best_idx_q, nxt_idx;
  logic [CNT_W-1:0]  best_val_q, nxt_val, cur_val;
  logic              best_vld_q, nxt_vld;

  btn_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_btn_debounce (
    .clk (clk),
    .rst (rst),
    .btn (start_btn),
    .rise(start_req)
  );

  // Argmin step: strict < keeps the lower index on ties.
  always_comb begin
    count_inc = count_q + 1'b1;
    cur_val   = res_q[cmp_idx_q];
    nxt_idx   = best_idx_q;
    nxt_val   = best_val_q;
    nxt_vld   = best_vld_q;
    if (!timed_out[cmp_idx_q] && (!best_vld_q || cur_val < best_val_q)) begin
      nxt_idx = cmp_idx_q;
      nxt_val = cur_val;
      nxt_vld = 1'b1;
    end
  end

  always_comb begin
    t_all = '0;
    for (int unsigned i = 0; i < N_COND; i++) begin
      t_all[slice_lo(i, CNT_W) +: CNT_W] = res_q[i];
    end
  end

  always_comb begin
    led = '0;
    if (disp_mode) begin
      led = LED_W'(progress_q);
    end else if (winner_vld) begin
      led = LED_W'(1) << winner;
    end else if (state_q == StDone) begin
      led = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cond_idx   <= '0;
      cond_start <= 1'b0;
      timed_out  <= '0;
      winner     <= '0;
      winner_vld <= 1'b0;
      busy       <= 1'b0;
      count_q    <= '0;
      progress_q <= '0;
      cmp_idx_q  <= '0;
      best_idx_q <= '0;
      best_val_q <= '0;
      best_vld_q <= 1'b0;
      for (int unsigned i = 0; i < N_COND; i++) res_q[i] <= '0;
    end else begin
      cond_start <= 1'b0;
      case (state_q)
        StIdle, StDone: begin
          if (start_req) begin
            for (int unsigned i = 0; i < N_COND; i++) res_q[i] <= '0;
            timed_out  <= '0;
            winner_vld <= 1'b0;
            progress_q <= '0;
            cond_idx   <= '0;
            cond_start <= 1'b1;
            busy       <= 1'b1;
            state_q    <= StStart;
          end
        end
        StStart: begin
          count_q <= '0;
          state_q <= StWait;
        end
        StWait: begin
          if (cond_done || count_inc == ToCnt) begin
            res_q[cond_idx]      <= cond_done ? count_inc : ToVal;
            timed_out[cond_idx]  <= ~cond_done;
            progress_q[cond_idx] <= 1'b1;
            if (cond_idx == LastIdx) begin
              cmp_idx_q  <= '0;
              best_vld_q <= 1'b0;
              state_q    <= StCmp;
            end else begin
              cond_idx   <= cond_idx + 1'b1;
              cond_start <= 1'b1;
              state_q    <= StStart;
            end
          end else begin
            count_q <= count_inc;
          end
        end
        StCmp: begin
          best_idx_q <= nxt_idx;
          best_val_q <= nxt_val;
          best_vld_q <= nxt_vld;
          cmp_idx_q  <= cmp_idx_q + 1'b1;
          if (cmp_idx_q == LastIdx) begin
            winner     <= nxt_idx;
            winner_vld <= nxt_vld;
            busy       <= 1'b0;
            state_q    <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/bench_sequencer.md
# bench_sequencer

Parametrised benchmark sequencer for the router-benchmark bring-up designs. It runs N_COND benchmark conditions back-to-back against an external engine through a start/done handshake, and measures each condition's latency in clock cycles, with a timeout. It then selects the fastest condition and drives the board LEDs with either the winner (one-hot) or per-condition progress. It sits between the board top level (clock, buttons, LEDs) and the benchmark engine. It adds debounced start, timeout and automatic winner selection.

## Interface
Parameters:
- N_COND, 4, number of conditions run per benchmark pass (2..LED_W)
- CNT_W, 32, width of each cycle-count result
- TIMEOUT, 2**24, cycle count at which a condition is abandoned (< 2**CNT_W - 1)
- DB_CYCLES, 1_250_000, cycles the start button must be stable to register (10 ms at 125 MHz)
- LED_W, 4, LED output width

Ports:
- clk  in  1  system clock; the only clock
- rst  in  1  reset, synchronous, active-high
- start_btn  in  1  raw asynchronous push-button; a rising edge starts a pass
- disp_mode  in  1  0 = winner one-hot, 1 = progress
- cond_idx  out  $clog2(N_COND)  index of the condition being run
- cond_start  out  1  one-cycle start pulse to the engine
- cond_done  in  1  engine completion; sampled only in WAIT
- t_all  out  N_COND*CNT_W  results; condition i occupies bits [i*CNT_W +: CNT_W]
- timed_out  out  N_COND  bit i set if condition i hit TIMEOUT
- winner  out  $clog2(N_COND)  index of the fastest condition
- winner_vld  out  1  winner is valid
- busy  out  1  pass in progress
- led  out  LED_W  LED drive

## Operation
- The start button passes through a 2-flop synchroniser and then the debouncer. The debounced level changes only after DB_CYCLES identical consecutive samples. A rising edge of the debounced level gives a 1-cycle start_req.
- FSM states are IDLE, START, WAIT, CMP and DONE:
  - IDLE/DONE, start_req: clear t_all, timed_out, winner_vld and the progress bits; set cond_idx=0; go to START. start_req is ignored in every other state.
  - START (1 cycle): cond_start=1; count<=0; go to WAIT.
  - WAIT, each cycle:
    - If cond_done: store count+1 into t_all[cond_idx]; set progress[cond_idx].
    - Else if count+1 == TIMEOUT: store all-ones; set timed_out[cond_idx] and progress[cond_idx].
    - Else: count<=count+1.
    - On store: if cond_idx==N_COND-1 go to CMP, else increment cond_idx and go to START.
  - CMP: iterative argmin, one condition per cycle for N_COND cycles. Timed-out entries are skipped; ties go to the lowest index. Then go to DONE. winner_vld=1 iff at least one entry did not time out.
  - DONE: results held until the next start_req or rst.
- A measured result is the number of cycles from the cycle after the cond_start pulse up to and including the cycle cond_done is sampled high. Its minimum is 1.
- A cond_done asserted in START is not sampled; the engine must not assert done before the pulse.
- busy=1 in START, WAIT and CMP.
- led mapping:
  - disp_mode=1: led[N_COND-1:0] = progress; upper bits 0.
  - disp_mode=0 with winner_vld: one-hot of winner.
  - disp_mode=0, in DONE with winner_vld=0: all ones.
  - disp_mode=0 otherwise: 0.

## Timing
- Reset values: FSM in IDLE; cond_start=0, cond_idx=0, t_all=0, timed_out=0, winner=0, winner_vld=0, busy=0, led=0. The debouncer and synchroniser state are cleared to 0.
- rst asserted mid-pass aborts immediately; all outputs take their reset values on the next edge.
- From start_req to the first cond_start: 1 cycle.
- From done sampled to the next cond_start: 1 cycle.
- From the last store to DONE: N_COND+1 cycles (CMP plus transition). winner and winner_vld update on entry to DONE.
- Button latency: 2 (sync) + DB_CYCLES + 1 cycles.
- All outputs are registered except led, which is a combinational decode of registered state.

## Structure
- Shared package bench_pkg: FSM state enum, the all-ones timeout constant function, and the result-slice helper for t_all.
- One sub-module, btn_debounce (synchroniser + stable counter + rising-edge pulse), parametrised by DB_CYCLES.

## Test plan
- Use DB_CYCLES=4, TIMEOUT=100, N_COND=4.
- Engine done latencies 10/5/20/7 -> t_all={10,5,20,7}, winner=1, winner_vld=1, led=4'b0010 in DONE.
- Latencies 8/8/30/8 -> winner=0 (tie to lowest index).
- Condition 2 never completes -> t_all[2]=all-ones and timed_out=4'b0100, reached after 100 cycles in WAIT; the pass continues with condition 3.
- All conditions time out -> winner_vld=0; led=4'b1111 with disp_mode=0.
- Button bounce 1-0-1 within 3 cycles -> no pass. Press held for 6 cycles -> exactly one pass. A second press while busy -> ignored.
- rst during WAIT of condition 2 -> next cycle IDLE with all outputs 0. A new press then runs a full pass from condition 0.
